// File: rtl/ram74189_access_ctrl_if.sv
// Bus bundle between the two requesters, the 74189 access controller and the RAM pins.
// Handshake: a requester holds *_req (with stable *_we/*_addr/*_wdata) until it sees its one-cycle
// *_gnt; the controller latches the request on that edge and pulses *_done when the access completes.
interface ram74189_access_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_cs_n;
  logic              ram_we_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic              busy;
  logic [1:0]        state;

  // Requesters and RAM side.
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_done, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_done, b_rdata,
    input  ram_cs_n, ram_we_n, ram_addr, ram_din,
    output ram_dout,
    input  busy, state
  );

  // Controller side.
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_done, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_done, b_rdata,
    output ram_cs_n, ram_we_n, ram_addr, ram_din,
    input  ram_dout,
    output busy, state
  );
endinterface

// File: rtl/ram74189_access_ctrl.sv
// Round-robin two-port sequencer for a 74189-style 16x4 RAM with complemented outputs.
// Every access runs IDLE -> SETUP -> STROBE x STROBE_CYCLES -> HOLD, all outputs registered.
module ram74189_access_ctrl #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 4,
  parameter int STROBE_CYCLES = 2
) (
  input logic                   clk,
  input logic                   reset,
  ram74189_access_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam int              CNT_W    = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

  logic [1:0]        state_q,    state_n;
  logic [CNT_W-1:0]  cnt_q,      cnt_n;
  logic              last_b_q,   last_b_n;
  logic              op_b_q,     op_b_n;
  logic              op_we_q,    op_we_n;
  logic [ADDR_W-1:0] addr_q,     addr_n;
  logic [DATA_W-1:0] din_q,      din_n;
  logic              cs_n_q,     cs_n_n;
  logic              we_n_q,     we_n_n;
  logic              a_gnt_q,    a_gnt_n;
  logic              b_gnt_q,    b_gnt_n;
  logic              a_done_q,   a_done_n;
  logic              b_done_q,   b_done_n;
  logic [DATA_W-1:0] a_rdata_q,  a_rdata_n;
  logic [DATA_W-1:0] b_rdata_q,  b_rdata_n;
  logic              busy_q,     busy_n;

  logic grant_a;
  logic grant_b;

  // On a tie the port that was not served last wins; last_b_q=1 means B was served last.
  assign grant_a = bus.a_req & (~bus.b_req | last_b_q);
  assign grant_b = bus.b_req & (~bus.a_req | ~last_b_q);

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    last_b_n  = last_b_q;
    op_b_n    = op_b_q;
    op_we_n   = op_we_q;
    addr_n    = addr_q;
    din_n     = din_q;
    cs_n_n    = cs_n_q;
    we_n_n    = we_n_q;
    a_gnt_n   = 1'b0;
    b_gnt_n   = 1'b0;
    a_done_n  = 1'b0;
    b_done_n  = 1'b0;
    a_rdata_n = a_rdata_q;
    b_rdata_n = b_rdata_q;

    case (state_q)
      ST_IDLE: begin
        cs_n_n = 1'b1;
        we_n_n = 1'b1;
        if (grant_a || grant_b) begin
          state_n  = ST_SETUP;
          op_b_n   = grant_b;
          last_b_n = grant_b;
          a_gnt_n  = grant_a;
          b_gnt_n  = grant_b;
          // The only place the RAM address/data pins may change.
          if (grant_b) begin
            op_we_n = bus.b_we;
            addr_n  = bus.b_addr;
            din_n   = bus.b_wdata;
          end else begin
            op_we_n = bus.a_we;
            addr_n  = bus.a_addr;
            din_n   = bus.a_wdata;
          end
          cs_n_n = 1'b0;
          we_n_n = 1'b1;
        end
      end

      ST_SETUP: begin
        state_n = ST_STROBE;
        cnt_n   = '0;
        cs_n_n  = 1'b0;
        we_n_n  = ~op_we_q;
      end

      ST_STROBE: begin
        if (cnt_q == CNT_LAST) begin
          state_n  = ST_HOLD;
          cs_n_n   = 1'b1;
          we_n_n   = 1'b1;
          a_done_n = ~op_b_q;
          b_done_n = op_b_q;
          // The RAM drives the complement of the stored word.
          if (!op_we_q) begin
            if (op_b_q) b_rdata_n = ~bus.ram_dout;
            else        a_rdata_n = ~bus.ram_dout;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        state_n = ST_IDLE;
        cs_n_n  = 1'b1;
        we_n_n  = 1'b1;
      end

      default: begin
        state_n = ST_IDLE;
        cs_n_n  = 1'b1;
        we_n_n  = 1'b1;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      op_b_q    <= 1'b0;
      op_we_q   <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      cs_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      last_b_q  <= last_b_n;
      op_b_q    <= op_b_n;
      op_we_q   <= op_we_n;
      addr_q    <= addr_n;
      din_q     <= din_n;
      cs_n_q    <= cs_n_n;
      we_n_q    <= we_n_n;
      a_gnt_q   <= a_gnt_n;
      b_gnt_q   <= b_gnt_n;
      a_done_q  <= a_done_n;
      b_done_q  <= b_done_n;
      a_rdata_q <= a_rdata_n;
      b_rdata_q <= b_rdata_n;
      busy_q    <= busy_n;
    end
  end

  assign bus.a_gnt    = a_gnt_q;
  assign bus.b_gnt    = b_gnt_q;
  assign bus.a_done   = a_done_q;
  assign bus.b_done   = b_done_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.ram_cs_n = cs_n_q;
  assign bus.ram_we_n = we_n_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;
  assign bus.busy     = busy_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_ram74189_access_ctrl.sv
// Bench for ram74189_access_ctrl: directed scenarios plus random two-port traffic, checked every
// cycle against a timeline model of the access (phase count since grant) and a shadow of RAM contents.
module tb_ram74189_access_ctrl;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int S  = 2;

  logic clk;
  logic reset;

  ram74189_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram74189_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no summary, required completion");
    $fatal(1);
  end

  // ---------------- RAM pin model (stores true data, outputs complement) ----------------
  logic [DW-1:0] mem [16];
  always @(posedge clk)
    if (!bus.ram_cs_n && !bus.ram_we_n) mem[bus.ram_addr] <= bus.ram_din;
  assign bus.ram_dout = bus.ram_cs_n ? {DW{1'bz}} : ~mem[bus.ram_addr];

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name);
    checks++;
    $display("FAIL %s: bound expired, required event did not occur at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_p counts cycles since the granting edge: 0 = setup, 1..S = strobe, S+1 = hold, then idle.
  bit            mv = 1'b0;
  bit            m_act;
  int            m_p;
  bit            m_own;
  bit            m_we;
  bit            m_last_b;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] e_ardata, e_brdata;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic          s_rst, s_ar, s_br, s_awe, s_bwe;
  logic [AW-1:0] s_aaddr, s_baddr;
  logic [DW-1:0] s_adata, s_bdata;

  always begin
    @(posedge clk);
    s_rst = reset;  s_ar = bus.a_req;  s_br = bus.b_req;
    s_awe = bus.a_we;  s_bwe = bus.b_we;
    s_aaddr = bus.a_addr;  s_baddr = bus.b_addr;
    s_adata = bus.a_wdata; s_bdata = bus.b_wdata;

    if (mv && m_act && m_we && m_p >= 1 && m_p <= S) shadow[m_addr] = m_data;

    if (s_rst) begin
      mv = 1'b1; m_act = 1'b0; m_p = 0; m_last_b = 1'b1;
      e_addr = '0; e_din = '0; e_ardata = '0; e_brdata = '0;
    end else if (mv) begin
      if (m_act) begin
        if (m_p == S && !m_we) begin
          if (m_own) e_brdata = shadow[m_addr];
          else       e_ardata = shadow[m_addr];
        end
        m_p++;
        if (m_p == S + 2) m_act = 1'b0;
      end else if (s_ar || s_br) begin
        m_own    = (s_ar && s_br) ? !m_last_b : s_br;
        m_last_b = m_own;
        m_act    = 1'b1;
        m_p      = 0;
        m_we     = m_own ? s_bwe : s_awe;
        m_addr   = m_own ? s_baddr : s_aaddr;
        m_data   = m_own ? s_bdata : s_adata;
        e_addr   = m_addr;
        e_din    = m_data;
      end
    end

    #1;
    if (mv) begin
      check("cs_n",    bus.ram_cs_n, !(m_act && m_p <= S));
      check("we_n",    bus.ram_we_n, !(m_act && m_we && m_p >= 1 && m_p <= S));
      check("ram_addr", bus.ram_addr, e_addr);
      check("ram_din", bus.ram_din, e_din);
      check("a_gnt",   bus.a_gnt,  m_act && m_p == 0 && !m_own);
      check("b_gnt",   bus.b_gnt,  m_act && m_p == 0 && m_own);
      check("a_done",  bus.a_done, m_act && m_p == S + 1 && !m_own);
      check("b_done",  bus.b_done, m_act && m_p == S + 1 && m_own);
      check("a_rdata", bus.a_rdata, e_ardata);
      check("b_rdata", bus.b_rdata, e_brdata);
      check("busy",    bus.busy,   m_act);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) note_fail("wait_idle");
  endtask

  // One access on a port; returns gnt->done cycles and cs_n/we_n low counts from gnt to done.
  task automatic access(input bit port_b, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output int lat, output int cs_lo, output int we_lo);
    int n;
    lat = -1; cs_lo = 0; we_lo = 0;
    @(negedge clk);
    if (port_b) begin bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data; end
    else        begin bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(port_b ? bus.b_gnt : bus.a_gnt) && n < 40);
    if (port_b) bus.b_req = 0; else bus.a_req = 0;
    if (n >= 40) begin note_fail("access_gnt"); return; end
    n = 0;
    while (!(port_b ? bus.b_done : bus.a_done) && n < 40) begin
      if (!bus.ram_cs_n) cs_lo++;
      if (!bus.ram_we_n) we_lo++;
      @(negedge clk); n++;
    end
    if (n >= 40) begin note_fail("access_done"); return; end
    if (!bus.ram_cs_n) cs_lo++;
    lat = n;
  endtask

  // ---------------- directed + random stimulus ----------------
  int lat, cs_lo, we_lo, n, gcount, last_g, ngnt, ndone;
  logic [DW-1:0] rnd;
  bit order_ok;

  initial begin
    reset = 1'b1;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 4'd3; bus.a_wdata = 4'h6;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 4'd7; bus.b_wdata = 4'h9;

    // T1: reset held 3 cycles with both requests high
    repeat (3) @(negedge clk);
    check("t1_cs_n", bus.ram_cs_n, 1);
    check("t1_we_n", bus.ram_we_n, 1);
    check("t1_addr", bus.ram_addr, 0);
    check("t1_din",  bus.ram_din, 0);
    check("t1_gnt",  {bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done}, 0);
    check("t1_busy", bus.busy, 0);
    reset = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.a_gnt || bus.b_gnt) && n < 10);
    if (n >= 10) note_fail("t1_gnt");
    check("t1_first_is_a", {bus.a_gnt, bus.b_gnt}, 2'b10);
    bus.a_req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.b_gnt && n < 20);
    if (n >= 20) note_fail("t1_b_gnt");
    bus.b_req = 0;
    @(negedge clk);
    wait_idle();

    // Fill every word so later reads are defined
    for (int i = 0; i < 16; i++) begin
      rnd = DW'($urandom_range(0, 15));
      access(0, 1, AW'(i), rnd, lat, cs_lo, we_lo);
    end

    // T2: A write addr 5 = 0xA
    access(0, 1, 4'd5, 4'hA, lat, cs_lo, we_lo);
    check("t2_latency", lat, 3);
    check("t2_cs_low",  cs_lo, 3);
    check("t2_we_low",  we_lo, 2);

    // T3: B read addr 5
    access(1, 0, 4'd5, 4'h0, lat, cs_lo, we_lo);
    check("t3_b_rdata", bus.b_rdata, 4'hA);
    check("t3_we_low",  we_lo, 0);

    // T4: both held for six accesses
    @(negedge clk);
    bus.a_we = 0; bus.a_addr = 4'd5; bus.b_we = 0; bus.b_addr = 4'd2;
    bus.a_req = 1; bus.b_req = 1;
    gcount = 0; last_g = 0; order_ok = 1; n = 0;
    while (gcount < 6 && n < 80) begin
      @(negedge clk); n++;
      if (bus.a_gnt || bus.b_gnt) begin
        check("t4_order", {bus.a_gnt, bus.b_gnt}, (gcount % 2 == 0) ? 2'b10 : 2'b01);
        if (gcount > 0) check("t4_spacing", n - last_g, 5);
        last_g = n;
        gcount++;
      end
    end
    if (gcount < 6) note_fail("t4_grants");
    bus.a_req = 0; bus.b_req = 0;
    @(negedge clk);
    wait_idle();

    // T5: reset in the second strobe cycle of an A write
    @(negedge clk);
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 4'd9; bus.a_wdata = 4'h3;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.a_gnt && n < 20);
    if (n >= 20) note_fail("t5_gnt");
    bus.a_req = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_cs_n", bus.ram_cs_n, 1);
    check("t5_we_n", bus.ram_we_n, 1);
    reset = 1'b0;
    ndone = 0;
    repeat (6) begin @(negedge clk); if (bus.a_done) ndone++; end
    check("t5_no_done", ndone, 0);
    bus.a_we = 0; bus.b_we = 0; bus.a_req = 1; bus.b_req = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.a_gnt || bus.b_gnt) && n < 10);
    check("t5_tie_a", {bus.a_gnt, bus.b_gnt}, 2'b10);
    bus.a_req = 0; bus.b_req = 0;
    @(negedge clk);
    wait_idle();

    // T6: boundary addresses, plus a one-cycle A pulse while busy
    access(0, 1, 4'd15, 4'hF, lat, cs_lo, we_lo);
    @(negedge clk);
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 4'd0; bus.a_wdata = 4'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.a_gnt && n < 20);
    bus.a_req = 0;
    @(negedge clk);
    bus.a_req = 1; bus.a_addr = 4'd7; bus.a_wdata = 4'h5;
    @(negedge clk);
    bus.a_req = 0;
    ngnt = 0;
    repeat (6) begin @(negedge clk); if (bus.a_gnt) ngnt++; end
    check("t6_pulse_ignored", ngnt, 0);
    access(0, 0, 4'd15, 4'h0, lat, cs_lo, we_lo);
    check("t6_rdata_f", bus.a_rdata, 4'hF);
    access(1, 0, 4'd0, 4'h5, lat, cs_lo, we_lo);
    check("t6_rdata_0", bus.b_rdata, 4'h0);

    // Random two-port traffic with occasional withdrawals and resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      if (bus.a_gnt) bus.a_req = 0;
      else if (bus.a_req && $urandom_range(0, 15) == 0) bus.a_req = 0;
      else if (!bus.a_req && $urandom_range(0, 3) == 0) begin
        bus.a_req = 1; bus.a_we = 1'($urandom_range(0, 1));
        bus.a_addr = AW'($urandom_range(0, 15)); bus.a_wdata = DW'($urandom_range(0, 15));
      end
      if (bus.b_gnt) bus.b_req = 0;
      else if (bus.b_req && $urandom_range(0, 15) == 0) bus.b_req = 0;
      else if (!bus.b_req && $urandom_range(0, 3) == 0) begin
        bus.b_req = 1; bus.b_we = 1'($urandom_range(0, 1));
        bus.b_addr = AW'($urandom_range(0, 15)); bus.b_wdata = DW'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    reset = 0; bus.a_req = 0; bus.b_req = 0;
    @(negedge clk);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
